bsg_axi_burst_master: RTL
=========================

Name: bsg_axi_burst_master

Overview:
- Synthesizable AXI4 initiator that turns simple single-command requests into fixed-length INCR bursts.
- Write commands drive the AW, W and B channels; read commands drive the AR and R channels.
- It is the counterpart of the nonsynth AXI memory responder, and sits between a client (DMA or test engine) and any AXI4 responder.
- At most one transaction is outstanding at a time.

Parameters:
- axi_id_width_p, 4, width of the AXI ID fields.
- axi_addr_width_p, 32, width of the AXI address.
- axi_data_width_p, 64, data width in bits; must be a power of two and ≥ 8.
- axi_burst_len_p, 4, beats per burst; range 1..256.
- id_p, 0, value driven on awid and arid.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- cmd_v_i  in  1  command valid.
- cmd_write_i  in  1  1 = write burst, 0 = read burst.
- cmd_addr_i  in  axi_addr_width_p  burst start byte address.
- cmd_ready_o  out  1  command accepted when cmd_v_i & cmd_ready_o.
- wdata_v_i / wdata_i / wdata_ready_o  in/in/out  1/axi_data_width_p/1  client write beats.
- rdata_v_o / rdata_o / rdata_last_o / rdata_ready_i  out/out/out/in  1/axi_data_width_p/1/1  read beats to client.
- done_v_o  out  1  one-cycle pulse at transaction end.
- done_err_o  out  1  error status, valid with done_v_o.
- axi_aw{id,addr,len,size,burst,valid}_o  out  id/addr/8/3/2/1  write address channel.
- axi_awready_i  in  1  write address ready.
- axi_w{data,strb,last,valid}_o  out  data/data÷8/1/1  write data channel.
- axi_wready_i  in  1  write data ready.
- axi_b{id,resp,valid}_i  in  id/2/1  write response channel.
- axi_bready_o  out  1  write response ready.
- axi_ar{id,addr,len,size,burst,valid}_o  out  as AW  read address channel.
- axi_arready_i  in  1  read address ready.
- axi_r{id,data,resp,last,valid}_i  in  id/data/2/1/1  read data channel.
- axi_rready_o  out  1  read data ready.

Behaviour:
- Reset: asynchronous on reset_n_i low. State goes to IDLE; beat counter, error flag and address register clear.
- Outputs during reset: all valid/ready outputs and done_v_o are 0. On the first cycle after release, cmd_ready_o=1.
- Reset mid-burst abandons the transaction with no done pulse.
- States: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA.
- IDLE:
  - cmd_ready_o=1.
  - On handshake, register the address with its low log2(data_width/8) bits forced to 0.
  - Clear the counter and error flag, then go to WR_ADDR or RD_ADDR.
- Constant address-channel fields: awlen/arlen = axi_burst_len_p-1; awsize/arsize = log2(axi_data_width_p/8); awburst/arburst = 2'b01; awid/arid = id_p; wstrb = all ones.
- WR_ADDR: awvalid_o=1 and held stable until awready_i, then go to WR_DATA. No W beat is presented before the AW handshake.
- WR_DATA:
  - Combinational pass-through: wvalid_o = wdata_v_i, wdata_ready_o = axi_wready_i, wdata_o = wdata_i.
  - wlast_o = (count == axi_burst_len_p-1).
  - The counter increments on each wvalid&wready.
  - The last-beat handshake goes to WR_RESP.
- WR_RESP: bready_o=1. On bvalid, set error if bresp≠0 or bid≠id_p, pulse done_v_o the next cycle, and go to IDLE.
- RD_ADDR: arvalid_o=1 and held until arready_i, then go to RD_DATA.
- RD_DATA:
  - Combinational pass-through: rdata_v_o = rvalid_i, axi_rready_o = rdata_ready_i, rdata_o = rdata_i, rdata_last_o = (count == axi_burst_len_p-1).
  - On each beat handshake, set error if rresp≠0, rid≠id_p, or rlast_i ≠ (count == len-1).
  - After the final beat (count == len-1), pulse done_v_o the next cycle and go to IDLE. An early rlast does not shorten the burst.
- done_v_o is registered, exactly one cycle; done_err_o is meaningful only when done_v_o=1.
- cmd_ready_o is 0 in every non-IDLE state and during the done cycle. The earliest next command is accepted one cycle after done_v_o.
- Counter width is clog2-safe of axi_burst_len_p. When axi_burst_len_p=1, wlast_o=1 on the only beat.
- Handshake stability: once a valid is asserted, it and its payload stay stable until ready. For W and R the client owns stability.

Test Plan:
- Write, addr 0x100, beats 0x11..0x44, responder always ready → awaddr=0x100, awlen=3, awsize=3, awburst=01; wlast only on 0x44; bresp=0 → done_v_o one cycle, done_err_o=0.
- Read, addr 0x107 → araddr=0x100. Beats D0..D3 returned with rdata_ready_i toggling 1/0 → all 4 beats delivered in order; rdata_last_o on D3; done_err_o=0.
- awready_i held low 5 cycles → awvalid_o and awaddr_o stable; wvalid_o=0 throughout; burst then completes normally.
- bresp=2'b10 on write; separately rresp=2'b11 on beat 1 of a read → done_err_o=1 in both cases.
- Read with rlast_i on beat 2 of 4 → error flagged; all 4 beats consumed; done_err_o=1.
- reset_n_i low during WR_DATA beat 2 → outputs 0 immediately; no done pulse; after release, cmd_ready_o=1 and a new read completes cleanly.

Source files
------------

// File: rtl/bsg_axi_burst_master_if.sv
// AXI4 bus bundle between the burst master and a responder.
// Master drives addresses/write data; slave drives readys and responses.
interface bsg_axi_burst_master_if #(
    parameter int id_w   = 4,
    parameter int addr_w = 32,
    parameter int data_w = 64
);
    logic [id_w-1:0]     awid;
    logic [addr_w-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [data_w-1:0]   wdata;
    logic [data_w/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [id_w-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [id_w-1:0]     arid;
    logic [addr_w-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [id_w-1:0]     rid;
    logic [data_w-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/bsg_axi_burst_master.sv
// AXI4 initiator: one client command becomes one fixed-length INCR burst.
// Single outstanding transaction; W and R beats pass straight through.
module bsg_axi_burst_master #(
    parameter int axi_id_width_p   = 4,
    parameter int axi_addr_width_p = 32,
    parameter int axi_data_width_p = 64,
    parameter int axi_burst_len_p  = 4,
    parameter int id_p             = 0
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        cmd_v_i,
    input  logic                        cmd_write_i,
    input  logic [axi_addr_width_p-1:0] cmd_addr_i,
    output logic                        cmd_ready_o,
    input  logic                        wdata_v_i,
    input  logic [axi_data_width_p-1:0] wdata_i,
    output logic                        wdata_ready_o,
    output logic                        rdata_v_o,
    output logic [axi_data_width_p-1:0] rdata_o,
    output logic                        rdata_last_o,
    input  logic                        rdata_ready_i,
    output logic                        done_v_o,
    output logic                        done_err_o,
    bsg_axi_burst_master_if.master      axi
);
    localparam int lg_bytes_lp = $clog2(axi_data_width_p/8);
    localparam int cnt_w_lp =
        (axi_burst_len_p > 1) ? $clog2(axi_burst_len_p) : 1;
    localparam logic [cnt_w_lp-1:0] last_lp =
        cnt_w_lp'(axi_burst_len_p-1);
    localparam logic [axi_id_width_p-1:0] id_lp =
        axi_id_width_p'(id_p);
    localparam logic [axi_addr_width_p-1:0] lo_mask_lp =
        axi_addr_width_p'((1 << lg_bytes_lp) - 1);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA
    } state_e;

    state_e                      state_q, state_d;
    logic [cnt_w_lp-1:0]         cnt_q, cnt_d;
    logic                        err_q, err_d;
    logic                        done_q, done_d;
    logic [axi_addr_width_p-1:0] addr_q, addr_d;
    logic                        is_last;
    logic                        cmd_rdy;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
        end
    end

    assign is_last = (cnt_q == last_lp);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        addr_d        = addr_q;
        done_d        = 1'b0;
        cmd_rdy       = 1'b0;
        axi.awvalid   = 1'b0;
        axi.arvalid   = 1'b0;
        axi.wvalid    = 1'b0;
        axi.bready    = 1'b0;
        axi.rready    = 1'b0;
        wdata_ready_o = 1'b0;
        rdata_v_o     = 1'b0;
        rdata_last_o  = 1'b0;
        axi.wlast     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // done cycle blocks the next command
                cmd_rdy = ~done_q;
                if (cmd_v_i && cmd_rdy) begin
                    addr_d  = cmd_addr_i & ~lo_mask_lp;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = cmd_write_i ? WR_ADDR : RD_ADDR;
                end
            end
            WR_ADDR: begin
                axi.awvalid = 1'b1;
                if (axi.awready) state_d = WR_DATA;
            end
            WR_DATA: begin
                axi.wvalid    = wdata_v_i;
                wdata_ready_o = axi.wready;
                axi.wlast     = is_last;
                if (wdata_v_i && axi.wready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (is_last) begin
                        cnt_d   = '0;
                        state_d = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                axi.bready = 1'b1;
                if (axi.bvalid) begin
                    err_d = err_q | (axi.bresp != 2'b00)
                          | (axi.bid != id_lp);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            RD_ADDR: begin
                axi.arvalid = 1'b1;
                if (axi.arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                rdata_v_o    = axi.rvalid;
                axi.rready   = rdata_ready_i;
                rdata_last_o = is_last;
                if (axi.rvalid && rdata_ready_i) begin
                    // count beats ourselves; rlast only flags errors
                    err_d = err_q | (axi.rresp != 2'b00)
                          | (axi.rid != id_lp)
                          | (axi.rlast != is_last);
                    cnt_d = cnt_q + 1'b1;
                    if (is_last) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready_o = cmd_rdy & reset_n_i;
    assign done_v_o    = done_q;
    assign done_err_o  = err_q;
    assign rdata_o     = axi.rdata;

    assign axi.awid    = id_lp;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = 8'(axi_burst_len_p-1);
    assign axi.awsize  = 3'(lg_bytes_lp);
    assign axi.awburst = 2'b01;
    assign axi.arid    = id_lp;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = 8'(axi_burst_len_p-1);
    assign axi.arsize  = 3'(lg_bytes_lp);
    assign axi.arburst = 2'b01;
    assign axi.wdata   = wdata_i;
    assign axi.wstrb   = '1;
endmodule
